// File: rtl/ocs_beam_counter.sv
// Beam-position generator for the OCS video path: line/frame strobes, line and column
// counters, interlace long/short alternation, vblank and an armed beam-position compare.
//
// Compare FSM states
//   state     | meaning
//   CMP_IDLE  | no compare pending
//   CMP_ARMED | target latched, waiting for the beam to reach it
module ocs_beam_counter #(
  parameter int CNT_W        = 11,
  parameter int LINE_W       = 9,
  parameter int COL_W        = 9,
  parameter int CLK_PER_LINE = 1920,
  parameter int PRE_OFFSET   = 1,
  parameter int COLUMN_START = 601,
  parameter int COLUMN_DIV   = 2,
  parameter int COLUMN_MAX   = 452,
  parameter int SHORT_LINES  = 312,
  parameter int VBLANK_LINES = 26
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              interlace_en,
  input  logic              cmp_arm,
  input  logic [LINE_W-1:0] cmp_line,
  input  logic [COL_W-1:0]  cmp_column,
  output logic              line_pre_start,
  output logic              line_start,
  output logic              frame_start,
  output logic [LINE_W-1:0] line_number,
  output logic [COL_W-1:0]  column_number,
  output logic              long_frame,
  output logic              vblank,
  output logic              cmp_armed,
  output logic              cmp_hit
);

  localparam int DIV_W = (COLUMN_DIV > 1) ? $clog2(COLUMN_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE    = CNT_W'(CLK_PER_LINE - 1 - PRE_OFFSET);
  localparam logic [CNT_W-1:0]  CNT_COL    = CNT_W'(COLUMN_START);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(COLUMN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_SAT    = COL_W'(COLUMN_MAX);
  localparam logic [LINE_W-1:0] LINE_SHORT = LINE_W'(SHORT_LINES - 1);
  localparam logic [LINE_W-1:0] LINE_LONG  = LINE_W'(SHORT_LINES);
  localparam logic [LINE_W-1:0] VB_LINES   = LINE_W'(VBLANK_LINES);

  typedef enum logic {
    CMP_IDLE  = 1'b0,
    CMP_ARMED = 1'b1
  } cmp_state_t;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              long_q, long_d;
  logic              pre_q, pre_d;
  logic              ls_q, ls_d;
  logic              fs_q, fs_d;
  logic              vblank_q, vblank_d;

  cmp_state_t        state_q, state_d;
  logic [LINE_W-1:0] tgt_line_q, tgt_line_d;
  logic [COL_W-1:0]  tgt_col_q, tgt_col_d;
  logic              hit_q, hit_d;

  logic wrap;
  logic in_window;
  logic col_step;
  logic frame_end;
  logic beam_reached;

  // Beam counters and strobes
  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    in_window = (cnt_q >= CNT_COL);
    col_step  = in_window && (div_q == '0) && (col_q < COL_SAT);
    frame_end = wrap && (long_q ? (line_q == LINE_LONG) : (line_q == LINE_SHORT));

    cnt_d = wrap ? '0 : cnt_q + 1'b1;

    // prescaler phase 0 lines up with COLUMN_START, giving the mod-COLUMN_DIV step
    div_d = div_q;
    if (wrap) begin
      div_d = '0;
    end else if (in_window) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    col_d = col_q;
    if (wrap) begin
      col_d = '0;
    end else if (col_step) begin
      col_d = col_q + 1'b1;
    end

    line_d = line_q;
    long_d = long_q;
    if (frame_end) begin
      line_d = '0;
      long_d = interlace_en & ~long_q;
    end else if (wrap) begin
      line_d = line_q + 1'b1;
    end

    pre_d    = (cnt_q == CNT_PRE);
    ls_d     = wrap;
    fs_d     = frame_end;
    vblank_d = (line_d < VB_LINES);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cnt_q    <= '0;
      div_q    <= '0;
      col_q    <= '0;
      line_q   <= '0;
      long_q   <= 1'b0;
      pre_q    <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      vblank_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      col_q    <= col_d;
      line_q   <= line_d;
      long_q   <= long_d;
      pre_q    <= pre_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      vblank_q <= vblank_d;
    end
  end

  // Compare is frame-relative: once the beam wraps to line 0 it cannot match a passed target
  always_comb begin
    beam_reached = (line_q > tgt_line_q) ||
                   ((line_q == tgt_line_q) && (col_q >= tgt_col_q));

    state_d    = state_q;
    tgt_line_d = tgt_line_q;
    tgt_col_d  = tgt_col_q;
    hit_d      = 1'b0;

    case (state_q)
      CMP_IDLE: begin
        if (cmp_arm) begin
          state_d    = CMP_ARMED;
          tgt_line_d = cmp_line;
          tgt_col_d  = cmp_column;
        end
      end
      CMP_ARMED: begin
        if (cmp_arm) begin
          tgt_line_d = cmp_line;
          tgt_col_d  = cmp_column;
        end else if (beam_reached) begin
          state_d = CMP_IDLE;
          hit_d   = 1'b1;
        end
      end
      default: state_d = CMP_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= CMP_IDLE;
      tgt_line_q <= '0;
      tgt_col_q  <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_line_q <= tgt_line_d;
      tgt_col_q  <= tgt_col_d;
      hit_q      <= hit_d;
    end
  end

  assign line_pre_start = pre_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;
  assign line_number    = line_q;
  assign column_number  = col_q;
  assign long_frame     = long_q;
  assign vblank         = vblank_q;
  assign cmp_armed      = (state_q == CMP_ARMED);
  assign cmp_hit        = hit_q;

endmodule

// File: tb/tb_ocs_beam_counter.sv
// Scoreboard bench for ocs_beam_counter, run with a shortened line/frame geometry
// so that several full frames fit in a short simulation.
module tb_ocs_beam_counter;

  localparam int CPL = 64;
  localparam int PRE = 3;
  localparam int CS  = 20;
  localparam int CD  = 3;
  localparam int CM  = 10;
  localparam int SL  = 40;
  localparam int VB  = 6;

  logic       CLK_I;
  logic       RST_I;
  logic       interlace_en;
  logic       cmp_arm;
  logic [8:0] cmp_line;
  logic [8:0] cmp_column;
  logic       line_pre_start;
  logic       line_start;
  logic       frame_start;
  logic [8:0] line_number;
  logic [8:0] column_number;
  logic       long_frame;
  logic       vblank;
  logic       cmp_armed;
  logic       cmp_hit;

  ocs_beam_counter #(
    .CNT_W(11), .LINE_W(9), .COL_W(9), .CLK_PER_LINE(CPL), .PRE_OFFSET(PRE),
    .COLUMN_START(CS), .COLUMN_DIV(CD), .COLUMN_MAX(CM), .SHORT_LINES(SL),
    .VBLANK_LINES(VB)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .interlace_en(interlace_en), .cmp_arm(cmp_arm),
    .cmp_line(cmp_line), .cmp_column(cmp_column), .line_pre_start(line_pre_start),
    .line_start(line_start), .frame_start(frame_start), .line_number(line_number),
    .column_number(column_number), .long_frame(long_frame), .vblank(vblank),
    .cmp_armed(cmp_armed), .cmp_hit(cmp_hit)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_line = 0;
  int ls_since_frame = 0;
  int frame_long  = 0;
  int frames_seen = 0;
  int hits_seen   = 0;
  int exp_len_q[$];
  int exp_long_q[$];
  int exp_hit_line_q[$];
  int exp_hit_col_q[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int exp_col(input int c);
    int v;
    if (c <= CS) return 0;
    v = (c - CS - 1) / CD + 1;
    return (v < CM) ? v : CM;
  endfunction

  // One clock, sampled 1 time unit after the edge; watches strobes and drains the scoreboard.
  task automatic tick();
    @(posedge CLK_I);
    #1;
    cyc++;
    if (line_pre_start) check_eq("pre_phase", cyc % CPL, CPL - PRE);
    if (line_start) begin
      check_eq("ls_phase", cyc % CPL, 0);
      ls_since_frame++;
      if (frame_start) exp_line = 0;
      else exp_line++;
      check_eq("ls_line", int'(line_number), exp_line);
      check_eq("ls_vblank", int'(vblank), (exp_line < VB) ? 1 : 0);
      if (exp_line == 1) frame_long = int'(long_frame);
    end
    if (frame_start) begin
      frames_seen++;
      check_eq("fs_with_ls", int'(line_start), 1);
      if (exp_len_q.size() > 0) begin
        check_eq("frame_len", ls_since_frame, exp_len_q.pop_front());
        check_eq("frame_long", frame_long, exp_long_q.pop_front());
      end
      ls_since_frame = 0;
    end
    if (cmp_hit) begin
      hits_seen++;
      check_eq("hit_armed_low", int'(cmp_armed), 0);
      if (exp_hit_line_q.size() > 0) begin
        check_eq("hit_line", int'(line_number), exp_hit_line_q.pop_front());
        check_eq("hit_col", int'(column_number), exp_hit_col_q.pop_front());
      end else begin
        check_eq("hit_unexpected", int'(cmp_hit), 0);
      end
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_pre", int'(line_pre_start), 0);
    check_eq("rst_ls", int'(line_start), 0);
    check_eq("rst_fs", int'(frame_start), 0);
    check_eq("rst_line", int'(line_number), 0);
    check_eq("rst_col", int'(column_number), 0);
    check_eq("rst_long", int'(long_frame), 0);
    check_eq("rst_vblank", int'(vblank), 1);
    check_eq("rst_armed", int'(cmp_armed), 0);
    check_eq("rst_hit", int'(cmp_hit), 0);
  endtask

  task automatic release_and_check_start();
    RST_I = 1'b0;
    cyc = 0;
    exp_line = 0;
    ls_since_frame = 0;
    for (int i = 0; i < 2 * CPL; i++) begin
      tick();
      if (line_pre_start) break;
    end
    check_eq("first_pre_cyc", cyc, CPL - PRE);
    for (int i = 0; i < 2 * CPL; i++) begin
      tick();
      if (line_start) break;
    end
    check_eq("first_ls_cyc", cyc, CPL);
    check_eq("first_ls_line", int'(line_number), 1);
    check_eq("first_ls_col", int'(column_number), 0);
    check_eq("first_ls_fs", int'(frame_start), 0);
  endtask

  task automatic wait_line(input int l);
    for (int i = 0; i < 3 * SL * CPL; i++) begin
      tick();
      if (line_start && exp_line == l) break;
    end
    check_eq("wait_line", int'(line_number), l);
  endtask

  task automatic wait_hits(input int n);
    for (int i = 0; i < 2 * SL * CPL; i++) begin
      if (hits_seen >= n) break;
      tick();
    end
    check_eq("hit_count", hits_seen, n);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 4 * (SL + 1) * CPL; i++) begin
      if (frames_seen >= n) break;
      tick();
    end
    check_eq("frame_count", frames_seen, n);
  endtask

  task automatic arm(input int l, input int c);
    cmp_line   = 9'(l);
    cmp_column = 9'(c);
    cmp_arm    = 1'b1;
    tick();
    cmp_arm    = 1'b0;
  endtask

  initial begin
    RST_I = 1'b1;
    interlace_en = 1'b0;
    cmp_arm = 1'b0;
    cmp_line = '0;
    cmp_column = '0;
    repeat (5) tick();
    check_reset_state();

    release_and_check_start();

    // column sweep across line 1, then the wrap back to column 0
    for (int c = 1; c < CPL; c++) begin
      tick();
      check_eq("col_sweep", int'(column_number), exp_col(c));
    end
    tick();
    check_eq("col_wrap", int'(column_number), 0);

    // interlaced frames: short, long, short; then interlace off keeps them short
    interlace_en = 1'b1;
    exp_len_q.push_back(SL);     exp_long_q.push_back(0);
    exp_len_q.push_back(SL + 1); exp_long_q.push_back(1);
    exp_len_q.push_back(SL);     exp_long_q.push_back(0);
    wait_frames(2);
    interlace_en = 1'b0;
    exp_len_q.push_back(SL); exp_long_q.push_back(0);
    exp_len_q.push_back(SL); exp_long_q.push_back(0);
    wait_frames(5);
    check_eq("frame_q_left", exp_len_q.size(), 0);

    // plain compare
    wait_line(10);
    exp_hit_line_q.push_back(30); exp_hit_col_q.push_back(5);
    arm(30, 5);
    check_eq("arm1_armed", int'(cmp_armed), 1);
    check_eq("arm1_nohit", int'(cmp_hit), 0);
    wait_hits(1);
    tick();
    check_eq("hit1_pulse", int'(cmp_hit), 0);

    // re-arm exactly on the matching cycle: old target must not fire
    wait_line(31);
    arm(34, 5);
    for (int i = 0; i < 5 * CPL; i++) begin
      if (line_number == 9'd34 && column_number == 9'd5) break;
      tick();
    end
    check_eq("at_old_target", int'(column_number), 5);
    exp_hit_line_q.push_back(38); exp_hit_col_q.push_back(5);
    arm(38, 5);
    check_eq("rearm_armed", int'(cmp_armed), 1);
    check_eq("rearm_nohit", int'(cmp_hit), 0);
    wait_hits(2);

    // target already passed: hit one cycle after arming
    wait_line(20);
    exp_hit_line_q.push_back(20); exp_hit_col_q.push_back(0);
    arm(5, 0);
    check_eq("imm_armed", int'(cmp_armed), 1);
    check_eq("imm_nohit_yet", int'(cmp_hit), 0);
    tick();
    check_eq("imm_hit", int'(cmp_hit), 1);

    // unreachable target stays armed across a frame wrap
    arm(SL + 5, 0);
    wait_line(3);
    check_eq("far_armed", int'(cmp_armed), 1);
    check_eq("far_hits", hits_seen, 3);

    // mid-line reset discards everything and restarts timing
    wait_line(30);
    repeat (30) tick();
    RST_I = 1'b1;
    tick();
    check_reset_state();
    release_and_check_start();
    check_eq("post_rst_armed", int'(cmp_armed), 0);

    check_eq("hit_q_left", exp_hit_line_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
